controlador_cruzamento: RTL
===========================

CONTROLADOR_CRUZAMENTO -- requirements
Module: controlador_cruzamento

Interface
REQ-001 SHALL have parameter VERDE, default 8'd1, green duration in cycles for A and B.
REQ-002 SHALL have parameter AMARELO, default 8'd3, yellow duration in cycles.
REQ-003 SHALL have parameter VERMELHO, default 8'd2, all-red clearance duration in cycles.
REQ-004 SHALL have parameter PEDESTRE, default 8'd4, pedestrian phase duration in cycles.
REQ-005 SHALL have port clk  input  1  the single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port bt_b  input  1  side-street (B) demand request.
REQ-008 SHALL have port bt_p  input  1  pedestrian crossing request.
REQ-009 SHALL have port cfg_we  input  1  duration register write strobe.
REQ-010 SHALL have port cfg_sel  input  2  register select: 0 verde, 1 amarelo, 2 vermelho, 3 pedestre.
REQ-011 SHALL have port cfg_dado  input  8  write data.
REQ-012 SHALL have port A  output  3  light A: 3'b001 verde, 3'b010 amarelo, 3'b100 vermelho.
REQ-013 SHALL have port B  output  3  light B, same encoding.
REQ-014 SHALL have port ped  output  1  pedestrian walk signal.
REQ-015 SHALL have port pend  output  2  pending requests {p,b}.

Function
REQ-016 SHALL implement states A_VERDE, A_AMARELO, LIMPA_1, B_VERDE, B_AMARELO, LIMPA_2, PED.
REQ-017 SHALL drive A=001/B=100 in A_VERDE, A=010/B=100 in A_AMARELO, A=100/B=001 in B_VERDE, A=100/B=010 in B_AMARELO, A=100/B=100 in LIMPA_1, LIMPA_2, PED; ped=1 only in PED.
REQ-018 SHALL keep every timed state for exactly N cycles, N being its duration register sampled at state entry.
REQ-019 SHALL hold A_VERDE past its N cycles until a request is pending (A is the default phase), then go to A_AMARELO on the next edge.
REQ-020 SHALL sequence A_AMARELO -> LIMPA_1 -> (B_VERDE or PED, per grant) and B_VERDE -> B_AMARELO -> LIMPA_2 -> A_VERDE and PED -> A_VERDE.
REQ-021 SHALL decide the grant on LIMPA_1 exit: sole pending request wins; both pending -> round-robin, the one not served last wins.
REQ-022 SHALL latch bt_b/bt_p as sticky requests on any rising clk edge where the input is high.
REQ-023 SHALL clear a request on the edge entering its served phase; clear beats set on that edge; a still-held button re-latches next edge.
REQ-024 SHALL update the selected duration register on cfg_we; written value 0 stored as 1; new value applies from the next state entry only.
REQ-025 SHALL use 8-bit down-counters saturating at 0; no wrap-around.

Reset
REQ-026 SHALL on rst enter A_VERDE with counter loaded from VERDE, A=001, B=100, ped=0, pend=00.
REQ-027 SHALL on rst reload duration registers from parameters and set round-robin pointer so B wins the first tie.
REQ-028 SHALL abort any phase immediately on rst mid-operation, no yellow/clearance completed.

Configuration
REQ-029 SHALL compile the pedestrian phase only when macro CRUZ_PEDESTRE_EN is defined.
REQ-030 SHALL without CRUZ_PEDESTRE_EN ignore bt_p, omit PED, tie ped=0 and pend[1]=0, write to cfg_sel=3 has no effect.

Verification
REQ-031 SHALL check: rst 1 cycle, no buttons, 20 cycles -> A=001, B=100 constant, pend=00.
REQ-032 SHALL check: bt_b high 1 cycle after reset -> A amarelo 3 cycles, all red 2, B verde 1, B amarelo 3, all red 2, A verde.
REQ-033 SHALL check: bt_b and bt_p raised same cycle -> B phase served first, then PED 4 cycles with ped=1, then A verde.
REQ-034 SHALL check: cfg_we, sel=0, dado=5 during A_VERDE -> current green unchanged, following B verde lasts 5 cycles; dado=0 -> 1 cycle.
REQ-035 SHALL check: rst asserted mid-B_AMARELO -> same instant A=001, B=100, pend=00.
REQ-036 SHALL check: CRUZ_PEDESTRE_EN undefined, bt_p pulsed -> no phase change, ped=0, pend=00.

Source files
------------

// File: rtl/controlador_cruzamento.sv
// controlador_cruzamento: two-way intersection controller with optional
// pedestrian phase. Street A is the default (rest) phase; street B and the
// pedestrian crossing are served on request, with round-robin arbitration
// when both are pending at the end of the first all-red clearance.
//
// Optional feature macro: CRUZ_PEDESTRE_EN
//   defined   -> PED phase, bt_p request latch and pedestre duration register
//   undefined -> bt_p ignored, ped = 0, pend[1] = 0, cfg_sel = 3 writes ignored
//
// Light encoding on A and B: 3'b001 verde, 3'b010 amarelo, 3'b100 vermelho.
//
// Every timed state lasts exactly N cycles, where N is its duration register
// value captured into the down-counter on the edge that enters the state.
// A_VERDE additionally holds past N cycles until a request is pending.
//
// dbg_estado mirrors the FSM state register for checkers and waveforms.

module controlador_cruzamento #(
    parameter logic [7:0] VERDE    = 8'd1,
    parameter logic [7:0] AMARELO  = 8'd3,
    parameter logic [7:0] VERMELHO = 8'd2,
    parameter logic [7:0] PEDESTRE = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_b,
    input  logic       bt_p,
    input  logic       cfg_we,
    input  logic [1:0] cfg_sel,
    input  logic [7:0] cfg_dado,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       ped,
    output logic [1:0] pend,
    output logic [2:0] dbg_estado
);

    typedef enum logic [2:0] {
        A_VERDE   = 3'd0,
        A_AMARELO = 3'd1,
        LIMPA_1   = 3'd2,
        B_VERDE   = 3'd3,
        B_AMARELO = 3'd4,
        LIMPA_2   = 3'd5
`ifdef CRUZ_PEDESTRE_EN
        ,
        PED       = 3'd6
`endif
    } estado_t;

    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;

    // A zero duration would make a state vanish; it is stored as 1 instead.
    function automatic logic [7:0] nz(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    estado_t    estado;
    estado_t    nxt;
    logic [7:0] cnt;
    logic [7:0] dur_verde;
    logic [7:0] dur_amarelo;
    logic [7:0] dur_vermelho;
    logic [7:0] dur_nxt;
    logic       pend_b;
    logic       pend_p;
    logic       ultimo_b;   // 1: B was the last request served (PED wins next tie)
    logic       fim;
    logic [2:0] luz_a_nxt;
    logic [2:0] luz_b_nxt;
    logic       ped_nxt;

`ifdef CRUZ_PEDESTRE_EN
    logic [7:0] dur_pedestre;
`else
    // bt_p has no function in this build.
    logic unused_bt_p;
    assign unused_bt_p = bt_p;
    assign pend_p      = 1'b0;
`endif

    assign fim        = (cnt <= 8'd1);
    assign pend       = {pend_p, pend_b};
    assign dbg_estado = estado;

    // Next-state decision: timed states leave when the counter expires.
    always_comb begin
        nxt = estado;
        case (estado)
            A_VERDE:   if (fim && (pend_b || pend_p)) nxt = A_AMARELO;
            A_AMARELO: if (fim) nxt = LIMPA_1;
            LIMPA_1: begin
                if (fim) begin
                    nxt = B_VERDE;
`ifdef CRUZ_PEDESTRE_EN
                    // Sole pedestrian request, or a tie where B was served last.
                    if (pend_p && (!pend_b || ultimo_b)) nxt = PED;
`endif
                end
            end
            B_VERDE:   if (fim) nxt = B_AMARELO;
            B_AMARELO: if (fim) nxt = LIMPA_2;
            LIMPA_2:   if (fim) nxt = A_VERDE;
`ifdef CRUZ_PEDESTRE_EN
            PED:       if (fim) nxt = A_VERDE;
`endif
            default:   nxt = A_VERDE;
        endcase
    end

    // Duration and light pattern of the state about to be entered.
    always_comb begin
        dur_nxt   = dur_verde;
        luz_a_nxt = LUZ_VERMELHO;
        luz_b_nxt = LUZ_VERMELHO;
        ped_nxt   = 1'b0;
        case (nxt)
            A_VERDE:   begin dur_nxt = dur_verde;    luz_a_nxt = LUZ_VERDE;   end
            A_AMARELO: begin dur_nxt = dur_amarelo;  luz_a_nxt = LUZ_AMARELO; end
            LIMPA_1:   begin dur_nxt = dur_vermelho; end
            B_VERDE:   begin dur_nxt = dur_verde;    luz_b_nxt = LUZ_VERDE;   end
            B_AMARELO: begin dur_nxt = dur_amarelo;  luz_b_nxt = LUZ_AMARELO; end
            LIMPA_2:   begin dur_nxt = dur_vermelho; end
`ifdef CRUZ_PEDESTRE_EN
            PED:       begin dur_nxt = dur_pedestre; ped_nxt = 1'b1;          end
`endif
            default:   begin dur_nxt = dur_verde;    luz_a_nxt = LUZ_VERDE;   end
        endcase
    end

    // FSM, counter, registered lights, request latches, arbiter pointer and
    // duration registers. Reset aborts any phase straight back to A_VERDE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado       <= A_VERDE;
            cnt          <= nz(VERDE);
            A            <= LUZ_VERDE;
            B            <= LUZ_VERMELHO;
            ped          <= 1'b0;
            pend_b       <= 1'b0;
            ultimo_b     <= 1'b0;
            dur_verde    <= nz(VERDE);
            dur_amarelo  <= nz(AMARELO);
            dur_vermelho <= nz(VERMELHO);
`ifdef CRUZ_PEDESTRE_EN
            pend_p       <= 1'b0;
            dur_pedestre <= nz(PEDESTRE);
`endif
        end else begin
            estado <= nxt;
            A      <= luz_a_nxt;
            B      <= luz_b_nxt;
            ped    <= ped_nxt;

            // Load on entry; otherwise count down, saturating at zero.
            if (nxt != estado) begin
                cnt <= dur_nxt;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end

            // Entering the served phase clears the request and wins over a
            // button still held on that edge.
            if (nxt == B_VERDE && estado != B_VERDE) begin
                pend_b   <= 1'b0;
                ultimo_b <= 1'b1;
            end else if (bt_b) begin
                pend_b <= 1'b1;
            end
`ifdef CRUZ_PEDESTRE_EN
            if (nxt == PED && estado != PED) begin
                pend_p   <= 1'b0;
                ultimo_b <= 1'b0;
            end else if (bt_p) begin
                pend_p <= 1'b1;
            end
`endif

            // Register writes only affect the counter at the next state entry.
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0:    dur_verde    <= nz(cfg_dado);
                    2'd1:    dur_amarelo  <= nz(cfg_dado);
                    2'd2:    dur_vermelho <= nz(cfg_dado);
`ifdef CRUZ_PEDESTRE_EN
                    2'd3:    dur_pedestre <= nz(cfg_dado);
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
